mac_pipe_param: RTL and testbench
=================================

# mac_pipe_param

Parametrised, pipelined signed multiply-accumulate unit, the next generation of the 8-bit MAC datapath. It accepts one operand pair per cycle under a `valid_in` strobe and accumulates `a*b` into a wide accumulator. Optional features are a multiplier pipeline stage, saturating or wrapping accumulation, a per-sample accumulator clear, and a sticky overflow flag. It sits between the operand source and the result consumer in the arithmetic pipeline.

## Interface
- `IN_W`, default 8: operand width, signed two's complement.
- `ACC_W`, default 20: accumulator/result width, signed. Must satisfy `ACC_W >= 2*IN_W`; elaboration fails otherwise.
- `MULT_PIPE`, default 1: 1 inserts a product register between multiplier and adder; 0 means no product register.
- `SAT`, default 1: 1 saturates the accumulator at signed limits; 0 wraps modulo 2^ACC_W.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `a`, input, IN_W: signed operand A.
- `b`, input, IN_W: signed operand B.
- `valid_in`, input, 1: `a`, `b` and `clear` are valid this cycle.
- `clear`, input, 1: sampled only with `valid_in`; this sample starts a new accumulation.
- `f`, output, ACC_W: accumulator value, registered.
- `valid_out`, output, 1: one-cycle pulse; `f` was updated at the preceding edge.
- `overflow`, output, 1: sticky flag for signed overflow since the last clear.

## Operation
- **Stage 0 (input regs)**
  - On an edge with `valid_in=1`, capture `a_r<=a`, `b_r<=b`, `c0<=clear`, `v0<=1`.
  - With `valid_in=0`: `v0<=0`; `a_r`, `b_r` and `c0` hold their values.
- **Stage 1 (product), MULT_PIPE=1 only**
  - `p_r<=a_r*b_r`, a signed full-precision 2*IN_W product; `c1<=c0`, `v1<=v0`.
  - With MULT_PIPE=0, the adder consumes `a_r*b_r` combinationally, using `c0` and `v0`.
- **Stage 2 (accumulate)**, when the product-valid bit is 1:
  - Sign-extend the product to ACC_W+1 bits.
  - Sum `s = (clear_tag ? 0 : f) + product`, computed at ACC_W+1 bits.
  - Overflow means `s` lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SAT=1: `f<=` the clamped value, either `2^(ACC_W-1)-1` or `-2^(ACC_W-1)`. Once saturated, `f` stays clamped while further same-sign products arrive. Opposite-sign products move it off the limit normally.
  - SAT=0: `f<=s[ACC_W-1:0]`, which wraps.
  - `overflow`: set on any overflowing update, whatever SAT is. A clear-tagged update reloads it from that update's own overflow result; with `ACC_W>=2*IN_W` this is always 0. Otherwise it is held.
  - `valid_out<=1` for exactly that cycle; otherwise `valid_out<=0`.
- When the product-valid bit is 0, `f` and `overflow` hold their values.
- A clear-tagged sample loads the product directly, so the old `f` is discarded that cycle.
- **Reset**
  - Asserting `reset`, at any time, immediately forces every register to 0: `a_r`, `b_r`, `p_r`, tags and valids, `f=0`, `valid_out=0`, `overflow=0`.
  - In-flight samples are discarded; none emerge after deassert.
- Simultaneous `valid_in` on consecutive cycles is fully supported at one sample per cycle. There is no backpressure and no stall input.

## Timing
- `valid_in` high in cycle n gives `valid_out` high in cycle n+2 when MULT_PIPE=0, or n+3 when MULT_PIPE=1. `f` carries the updated value during the same cycle.
- Throughput: 1 sample/cycle; N back-to-back inputs produce N back-to-back `valid_out` pulses. Gaps in the input are preserved in the output.
- `f` is stable, holding its last value, in cycles where `valid_out=0`.
- Reset values:
  - `f=0`, `valid_out=0`, `overflow=0`, applied asynchronously.
  - The first edge after deassert with `valid_in=1` is accepted normally.
- Critical path: the multiplier when MULT_PIPE=0, or the ACC_W+1 adder plus clamp mux when MULT_PIPE=1.

## Test plan
All scenarios use IN_W=8, ACC_W=20, MULT_PIPE=1 unless stated otherwise.
- **Basic accumulate:** reset, then `valid_in` pulses with (3,4,clear=1), (−5,6,0), (7,−2,0). Required response: `f`=12, −18, −32 on `valid_out` in cycles n+3, n+4, n+5. `overflow=0` throughout.
- **Latency / gaps / MULT_PIPE=0:** inputs (2,2,1), idle, (1,1,0). Required response: `valid_out` pulses 2 cycles after each input, with the gap preserved; `f`=4, then 5.
- **Saturation, SAT=1:**
  - 32 consecutive (−128,−128) samples, the first tagged clear. `f` reaches 507904 after 31 samples; the 32nd gives 524287 and `overflow=1`.
  - A following (−1,1,0) gives `f`=524286, with `overflow` still 1.
- **Wrap, SAT=0:** the same 32 samples. The 32nd gives `f`=−524288 and `overflow=1`; a following (1,1,clear=1) gives `f`=1 and `overflow=0`.
- **Negative limit, SAT=1:** 33 samples of (−128,127) after a clear, each −16256. Required response: `f` clamps to −524288 on the 33rd sample, with `overflow=1`.
- **Reset mid-flight:** issue 3 back-to-back samples, then assert `reset` for 1 cycle after the 2nd sample is accepted. Required response: `f`, `valid_out` and `overflow` drop to 0 immediately, and no `valid_out` follows. A fresh (9,9,1) then yields `f`=81.

Source files
------------

// File: rtl/mac_pipe_param_if.sv
// Operand/result bundle for mac_pipe_param: operands and strobe flow in,
// accumulator value, its update pulse and the sticky overflow flag flow out.
interface mac_pipe_param_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20
);
  logic signed [IN_W-1:0]  a;
  logic signed [IN_W-1:0]  b;
  logic                    valid_in;
  logic                    clear;
  logic signed [ACC_W-1:0] f;
  logic                    valid_out;
  logic                    overflow;

  // Valid-only protocol, no ready: a/b/clear are consumed on every edge where
  // valid_in=1, and valid_out pulses for one cycle each time f is updated.
  modport master (
    output a, b, valid_in, clear,
    input  f, valid_out, overflow
  );

  modport slave (
    input  a, b, valid_in, clear,
    output f, valid_out, overflow
  );
endinterface

// File: rtl/mac_pipe_param.sv
// Pipelined signed multiply-accumulate: input registers, optional product
// register, then an ACC_W+1 bit accumulate stage with saturate/wrap and sticky overflow.
module mac_pipe_param #(
  parameter int IN_W      = 8,
  parameter int ACC_W     = 20,
  parameter int MULT_PIPE = 1,
  parameter int SAT       = 1
) (
  input  logic            clk,
  input  logic            reset,
  mac_pipe_param_if.slave bus
);

  localparam int PW = 2 * IN_W;

  if (ACC_W < PW) begin : g_bad_width
    $error("mac_pipe_param: ACC_W must be >= 2*IN_W");
  end

  // Stage 0: operand capture; operands and clear tag hold while idle
  logic signed [IN_W-1:0] r_a;
  logic signed [IN_W-1:0] r_b;
  logic                   r_c0;
  logic                   r_v0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_c0 <= 1'b0;
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= bus.valid_in;
      if (bus.valid_in) begin
        r_a  <= bus.a;
        r_b  <= bus.b;
        r_c0 <= bus.clear;
      end
    end
  end

  logic signed [PW-1:0] w_mult;
  logic signed [PW-1:0] w_prod;
  logic                 w_clr;
  logic                 w_vld;

  assign w_mult = r_a * r_b;

  if (MULT_PIPE != 0) begin : g_pipe
    logic signed [PW-1:0] r_p;
    logic                 r_c1;
    logic                 r_v1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_p  <= '0;
        r_c1 <= 1'b0;
        r_v1 <= 1'b0;
      end else begin
        r_p  <= w_mult;
        r_c1 <= r_c0;
        r_v1 <= r_v0;
      end
    end

    assign w_prod = r_p;
    assign w_clr  = r_c1;
    assign w_vld  = r_v1;
  end else begin : g_comb
    assign w_prod = w_mult;
    assign w_clr  = r_c0;
    assign w_vld  = r_v0;
  end

  // Accumulate one bit wider than f so overflow is visible as a sign disagreement
  logic signed [ACC_W-1:0] r_f;
  logic                    r_vout;
  logic                    r_ovf;

  logic signed [ACC_W:0]   w_prod_x;
  logic signed [ACC_W:0]   w_base;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_limit;
  logic signed [ACC_W-1:0] w_next_f;
  logic                    w_next_ovf;

  assign w_prod_x = {{(ACC_W + 1 - PW){w_prod[PW-1]}}, w_prod};
  assign w_base   = w_clr ? '0 : {r_f[ACC_W-1], r_f};
  assign w_sum    = w_base + w_prod_x;
  assign w_ovf    = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  // The true sign of the sum picks which rail to clamp to
  assign w_limit    = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
  assign w_next_f   = ((SAT != 0) && w_ovf) ? w_limit : w_sum[ACC_W-1:0];
  assign w_next_ovf = w_clr ? w_ovf : (r_ovf | w_ovf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f    <= '0;
      r_vout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_vout <= w_vld;
      if (w_vld) begin
        r_f   <= w_next_f;
        r_ovf <= w_next_ovf;
      end
    end
  end

  assign bus.f         = r_f;
  assign bus.valid_out = r_vout;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_mac_pipe_param.sv
// Bench for mac_pipe_param: three configurations driven with identical
// stimulus, each checked against an integer reference model via expected queues.
module tb_mac_pipe_param;

  localparam int IN_W  = 8;
  localparam int ACC_W = 20;
  localparam int EW    = 32 + 1 + ACC_W;
  localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W - 1));

  // Instance 0: MULT_PIPE=1 SAT=1, 1: MULT_PIPE=0 SAT=1, 2: MULT_PIPE=1 SAT=0
  int lat [3] = '{3, 2, 3};
  bit sat [3] = '{1'b1, 1'b1, 1'b0};

  logic clk;
  logic tb_rst;
  logic signed [IN_W-1:0] tb_a;
  logic signed [IN_W-1:0] tb_b;
  logic tb_vin;
  logic tb_clr;
  int   cyc;

  mac_pipe_param_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus0 ();
  mac_pipe_param_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus1 ();
  mac_pipe_param_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus2 ();

  mac_pipe_param #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_PIPE(1), .SAT(1)) u_dut0 (
    .clk(clk), .reset(tb_rst), .bus(bus0));
  mac_pipe_param #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_PIPE(0), .SAT(1)) u_dut1 (
    .clk(clk), .reset(tb_rst), .bus(bus1));
  mac_pipe_param #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_PIPE(1), .SAT(0)) u_dut2 (
    .clk(clk), .reset(tb_rst), .bus(bus2));

  assign bus0.a = tb_a;  assign bus0.b = tb_b;  assign bus0.valid_in = tb_vin;  assign bus0.clear = tb_clr;
  assign bus1.a = tb_a;  assign bus1.b = tb_b;  assign bus1.valid_in = tb_vin;  assign bus1.clear = tb_clr;
  assign bus2.a = tb_a;  assign bus2.b = tb_b;  assign bus2.valid_in = tb_vin;  assign bus2.clear = tb_clr;

  logic signed [ACC_W-1:0] mon_f [3];
  logic                    mon_v [3];
  logic                    mon_o [3];
  assign mon_f[0] = bus0.f;  assign mon_v[0] = bus0.valid_out;  assign mon_o[0] = bus0.overflow;
  assign mon_f[1] = bus1.f;  assign mon_v[1] = bus1.valid_out;  assign mon_o[1] = bus1.overflow;
  assign mon_f[2] = bus2.f;  assign mon_v[2] = bus2.valid_out;  assign mon_o[2] = bus2.overflow;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q [3][$];
  longint m_f [3];
  bit     m_ovf [3];
  logic signed [ACC_W-1:0] last_f [3];
  logic                    last_ovf [3];
  logic signed [ACC_W-1:0] prev_f [3];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model(input int i, input longint a, input longint b, input bit clr);
    longint s;
    longint nf;
    bit     o;
    s = (clr ? 64'sd0 : m_f[i]) + a * b;
    o = (s > MAXV) || (s < MINV);
    if (!o)          nf = s;
    else if (sat[i]) nf = (s > MAXV) ? MAXV : MINV;
    else begin
      nf = s & ((64'sd1 <<< ACC_W) - 1);
      if (nf > MAXV) nf = nf - (64'sd1 <<< ACC_W);
    end
    m_f[i]   = nf;
    m_ovf[i] = clr ? o : (m_ovf[i] | o);
    exp_q[i].push_back({32'(cyc + lat[i]), m_ovf[i], ACC_W'(nf)});
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int a, input int b, input bit clr);
    @(negedge clk);
    tb_a   = IN_W'(a);
    tb_b   = IN_W'(b);
    tb_clr = clr;
    tb_vin = 1'b1;
    for (int i = 0; i < 3; i++) model(i, longint'(a), longint'(b), clr);
  endtask

  task automatic idle();
    @(negedge clk);
    tb_vin = 1'b0;
    tb_clr = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 40 && pending() != 0; k++) @(negedge clk);
    chk("drain_pending", pending(), 0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      m_f[i]   = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (mon_v[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("spurious_vout%0d", i), 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("f%0d", i), mon_f[i], $signed(e[ACC_W-1:0]));
            chk($sformatf("ovf%0d", i), mon_o[i], e[ACC_W]);
            chk($sformatf("lat%0d", i), cyc, e[EW-1:ACC_W+1]);
          end
          last_f[i]   = mon_f[i];
          last_ovf[i] = mon_o[i];
        end else if (tb_rst === 1'b0) begin
          chk($sformatf("hold%0d", i), mon_f[i], prev_f[i]);
        end
        prev_f[i] = mon_f[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tb_rst = 1'b1;
    tb_vin = 1'b0;
    tb_clr = 1'b0;
    tb_a   = '0;
    tb_b   = '0;
    reset_model();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_f%0d", i), mon_f[i], 0);
      chk($sformatf("rst_vout%0d", i), mon_v[i], 0);
      chk($sformatf("rst_ovf%0d", i), mon_o[i], 0);
    end
    tb_rst = 1'b0;

    // Basic accumulate
    drive(3, 4, 1'b1);
    drive(-5, 6, 1'b0);
    drive(7, -2, 1'b0);
    drain();
    chk("basic_f0", last_f[0], -32);
    chk("basic_ovf0", last_ovf[0], 0);
    chk("basic_f1", last_f[1], -32);

    // Gap preserved, two-cycle latency on the unpipelined instance
    drive(2, 2, 1'b1);
    idle();
    drive(1, 1, 1'b0);
    drain();
    chk("gap_f1", last_f[1], 5);

    // Positive saturation / wrap
    for (int j = 0; j < 32; j++) drive(-128, -128, j == 0);
    drain();
    chk("sat_f0", last_f[0], 524287);
    chk("sat_ovf0", last_ovf[0], 1);
    chk("wrap_f2", last_f[2], -524288);
    chk("wrap_ovf2", last_ovf[2], 1);
    drive(-1, 1, 1'b0);
    drain();
    chk("unsat_f0", last_f[0], 524286);
    chk("unsat_ovf0", last_ovf[0], 1);
    drive(1, 1, 1'b1);
    drain();
    chk("clr_f2", last_f[2], 1);
    chk("clr_ovf2", last_ovf[2], 0);

    // Negative limit
    for (int j = 0; j < 33; j++) drive(-128, 127, j == 0);
    drain();
    chk("neg_f0", last_f[0], -524288);
    chk("neg_ovf0", last_ovf[0], 1);

    // Random operands, random clears and gaps
    for (int j = 0; j < 60; j++) begin
      if ($urandom_range(0, 3) == 0) idle();
      drive(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            (j == 0) || ($urandom_range(0, 7) == 0));
    end
    drain();

    // Reset while samples are in flight
    drive(5, 5, 1'b1);
    drive(6, 6, 1'b0);
    @(negedge clk);
    tb_a = 8'sd7;  tb_b = 8'sd7;  tb_clr = 1'b0;  tb_vin = 1'b1;
    #2 tb_rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_f%0d", i), mon_f[i], 0);
      chk($sformatf("midrst_vout%0d", i), mon_v[i], 0);
      chk($sformatf("midrst_ovf%0d", i), mon_o[i], 0);
    end
    reset_model();
    @(negedge clk);
    tb_rst = 1'b0;
    tb_vin = 1'b0;
    repeat (6) @(negedge clk);
    drive(9, 9, 1'b1);
    drain();
    chk("post_rst_f0", last_f[0], 81);
    chk("post_rst_f1", last_f[1], 81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
